// File: rtl/adc128s_a2d_model.sv
// SPI A2D model: 8-ch 12-bit ADC128S-style slave (mode 0, 16-bit frames).
// Ports: clk, rst_n, SS_n, SCLK, MOSI -> MISO; lft/rght/batt 12-bit set values.
module adc128s_a2d_model (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  input  logic [11:0] batt_set
);

  logic        ss_ff1, ss_ff2, ss_ff3;
  logic        sclk_ff1, sclk_ff2, sclk_ff3;
  logic        ss_fall, ss_rise;
  logic        sclk_rise, sclk_fall;
  logic        ss_low;
  logic [2:0]  chnl;
  logic [15:0] tx_shift;
  // Only bits [13:11] of the command matter.
  logic [13:0] rx_shift;
  logic [4:0]  bit_cnt;
  logic [11:0] chnl_val;

  // SS_n idles high, so its synchronizer resets high to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff1   <= 1'b1;
      ss_ff2   <= 1'b1;
      ss_ff3   <= 1'b1;
      sclk_ff1 <= 1'b0;
      sclk_ff2 <= 1'b0;
      sclk_ff3 <= 1'b0;
    end else begin
      ss_ff1   <= SS_n;
      ss_ff2   <= ss_ff1;
      ss_ff3   <= ss_ff2;
      sclk_ff1 <= SCLK;
      sclk_ff2 <= sclk_ff1;
      sclk_ff3 <= sclk_ff2;
    end
  end

  assign ss_fall   = ss_ff3 & ~ss_ff2;
  assign ss_rise   = ~ss_ff3 & ss_ff2;
  assign sclk_rise = ~sclk_ff3 & sclk_ff2;
  assign sclk_fall = sclk_ff3 & ~sclk_ff2;
  assign ss_low    = ~ss_ff2;

  always_comb begin
    chnl_val = 12'h000;
    case (chnl)
      3'd0:    chnl_val = lft_cell_set;
      3'd4:    chnl_val = rght_cell_set;
      3'd5:    chnl_val = batt_set;
      default: chnl_val = 12'h000;
    endcase
  end

  // Frame boundaries take priority over SCLK edges in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnl     <= 3'd0;
      tx_shift <= 16'h0000;
      rx_shift <= 14'h0000;
      bit_cnt  <= 5'd0;
    end else if (ss_rise) begin
      if (bit_cnt == 5'd16)
        chnl <= rx_shift[13:11];
    end else if (ss_fall) begin
      tx_shift <= {4'h0, chnl_val};
      rx_shift <= 14'h0000;
      bit_cnt  <= 5'd0;
    end else if (ss_low) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[12:0], MOSI};
        if (bit_cnt != 5'd31)
          bit_cnt <= bit_cnt + 5'd1;
      end else if (sclk_fall) begin
        tx_shift <= {tx_shift[14:0], 1'b0};
      end
    end
  end

  assign MISO = tx_shift[15];

endmodule

// File: tb/tb_adc128s_a2d_model.sv
// Directed bench for adc128s_a2d_model: SPI frames with hand-computed
// responses, abort, back-to-back and mid-frame reset cases.
module tb_adc128s_a2d_model;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] lft_cell_set;
  logic [11:0] rght_cell_set;
  logic [11:0] batt_set;

  int checks;
  int failures;

  adc128s_a2d_model dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SS_n          (SS_n),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set),
    .batt_set      (batt_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    MOSI = b;
    wait_clk(5);
    r = MISO;
    SCLK = 1'b1;
    wait_clk(5);
    SCLK = 1'b0;
  endtask

  // nbits SCLKs; optionally change batt_set after bit chg_at.
  task automatic frame(input logic [15:0] cmd,
                       input int nbits,
                       input int chg_at,
                       input logic [11:0] new_batt,
                       output logic [15:0] resp);
    logic r;
    resp = 16'h0000;
    ss_low();
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(cmd[15-i], r);
      resp = {resp[14:0], r};
      if (i == chg_at) batt_set = new_batt;
    end
    wait_clk(5);
    ss_high();
  endtask

  logic [15:0] resp;
  logic        r;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    lft_cell_set = 12'h110;
    rght_cell_set = 12'h000;
    batt_set = 12'h000;
    wait_clk(3);
    check("reset_miso", {15'h0, MISO}, 16'h0000);
    rst_n = 1'b1;
    wait_clk(3);

    frame(16'h0000, 16, -1, 12'h000, resp);
    check("first_frame_lft", resp, 16'h0110);

    rght_cell_set = 12'h100;
    frame(16'h2000, 16, -1, 12'h000, resp);
    check("cmd_ch4_resp_lft", resp, 16'h0110);
    frame(16'h2800, 16, -1, 12'h000, resp);
    check("ch4_rght", resp, 16'h0100);

    batt_set = 12'hABC;
    frame(16'h2800, 16, 4, 12'h123, resp);
    check("ch5_batt_sampled", resp, 16'h0ABC);
    frame(16'h3000, 16, -1, 12'h123, resp);
    check("ch5_batt_new", resp, 16'h0123);
    frame(16'h0000, 16, -1, 12'h000, resp);
    check("ch6_zero", resp, 16'h0000);

    frame(16'h2000, 8, -1, 12'h123, resp);
    check("abort_partial", resp, 16'h0001);
    frame(16'h0800, 16, -1, 12'h123, resp);
    check("after_abort_lft", resp, 16'h0110);
    frame(16'h0000, 16, -1, 12'h123, resp);
    check("ch1_zero", resp, 16'h0000);

    // Back-to-back: SS_n high for a single clk between frames.
    resp = 16'h0000;
    ss_low();
    for (int i = 0; i < 16; i++) begin
      xfer_bit(i == 2, r);
      resp = {resp[14:0], r};
    end
    wait_clk(5);
    check("b2b_frame1_lft", resp, 16'h0110);
    SS_n = 1'b1;
    wait_clk(1);
    frame(16'h2800, 16, -1, 12'h123, resp);
    check("b2b_frame2_rght", resp, 16'h0100);

    // chnl is 5 now; this frame carries 0x0123.
    ss_low();
    for (int i = 0; i < 7; i++) xfer_bit(1'b0, r);
    wait_clk(5);
    check("midframe_miso", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b0;
    wait_clk(2);
    check("midframe_reset_miso", {15'h0, MISO}, 16'h0000);
    SS_n = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    frame(16'h0000, 16, -1, 12'h123, resp);
    check("post_reset_lft", resp, 16'h0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
